request_unit: RTL and testbench
===============================

REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 Parameter WORD_ADDR_W, default 30, SHALL set the link-address compare width (bits [31:2] of address).
REQ-002 CLK  in  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-003 nRST  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 dRENi  in  1  SHALL be the decoded data-read request from the control unit.
REQ-005 dWENi  in  1  SHALL be the decoded data-write request from the control unit.
REQ-006 datomic  in  1  SHALL mark the current request as LL (with dRENi) or SC (with dWENi).
REQ-007 daddr  in  32  SHALL be the data address of the current request.
REQ-008 ihit  in  1  SHALL indicate that the instruction fetch completed this cycle.
REQ-009 dhit  in  1  SHALL indicate that the data access completed this cycle.
REQ-010 inv_valid  in  1  SHALL flag a coherence invalidation this cycle.
REQ-011 inv_addr  in  32  SHALL be the invalidated address.
REQ-012 dREN  out  1  SHALL be the registered data-read request to the cache.
REQ-013 dWEN  out  1  SHALL be the registered data-write request to the cache.
REQ-014 sc_result  out  32  SHALL be the SC writeback value: 1 on success, 0 on failure.
REQ-015 busy  out  1  SHALL be high while a data request is outstanding.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, REQ, SCFAIL.
REQ-017 In IDLE, on ihit with dRENi or dWENi, it SHALL latch the operation kind and address.
REQ-018 On that same edge it SHALL enter REQ and assert dREN or dWEN from the next cycle.
REQ-019 Exception to REQ-018: for an SC with an invalid link or a link-address mismatch, it SHALL enter SCFAIL and SHALL NOT assert dWEN.
REQ-020 In REQ, dREN/dWEN SHALL hold steady until dhit.
REQ-021 On dhit in REQ, the FSM SHALL return to IDLE and dREN/dWEN SHALL be low the following cycle.
REQ-022 SCFAIL SHALL last exactly one cycle, with sc_result=0, then return to IDLE.
REQ-023 dREN and dWEN SHALL never be high simultaneously.
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 In IDLE, ihit without dRENi or dWENi SHALL leave the state unchanged.
REQ-026 In IDLE, dRENi or dWENi without ihit SHALL be ignored.
REQ-027 An LL completing on dhit SHALL set link_valid=1 and link_addr=daddr[31:2].
REQ-028 An SC completing on dhit SHALL clear link_valid; sc_result SHALL be 1 in that cycle.
REQ-029 Any non-atomic write completing to link_addr SHALL clear link_valid.
REQ-030 inv_valid with inv_addr[31:2]==link_addr SHALL clear link_valid on the next edge.
REQ-031 An invalidation and an LL completion in the same cycle: the LL set SHALL win.
REQ-032 An invalidation matching an SC's address in its issue cycle SHALL force the SCFAIL path.
REQ-033 sc_result SHALL be 0 in all cycles other than those named in REQ-028.

Reset
REQ-034 When nRST is low: state=IDLE, dREN=0, dWEN=0, busy=0, sc_result=0, link_valid=0, link_addr=0.
REQ-035 Reset asserted in REQ or SCFAIL SHALL abandon the request with no further memory request issued.

Configuration
REQ-036 With macro LLSC_EN defined: link register, SCFAIL state and REQ-019/027-032 SHALL be present.
REQ-037 Without LLSC_EN: datomic SHALL be ignored, SC SHALL behave as SW, sc_result SHALL read constant 1, and SCFAIL SHALL be unreachable.

Structure
REQ-038 Enum ru_state_t {IDLE, REQ, SCFAIL} SHALL live in control_unit_types_pkg.
REQ-039 The link-address width constant SHALL live in control_unit_types_pkg.
REQ-040 The link register SHALL be sub-module link_register (set, clear, inv compare, valid/addr outputs), instantiated only under LLSC_EN.

Verification
REQ-041 LW: ihit, dRENi=1, daddr=0x100 -> dREN=1 next cycle, held 3 cycles until dhit, then 0; busy mirrors.
REQ-042 LL 0x200 then SC 0x200 -> dWEN asserted; sc_result=1 on dhit; link_valid=0 afterward.
REQ-043 LL 0x200, inv_valid inv_addr=0x200, then SC 0x200 -> SCFAIL one cycle, sc_result=0, dWEN never high.
REQ-044 LL 0x200, SW 0x204 (different word), then SC 0x200 -> SC succeeds; repeat with SW 0x200 -> SC fails.
REQ-045 nRST low mid-REQ with dWEN=1 -> dWEN=0 immediately (asynchronously), state IDLE, link cleared.
REQ-046 Build without LLSC_EN: SC to an unlinked address -> dWEN asserted; sc_result=1.

Source files
------------

// File: rtl/control_unit_types_pkg.sv
// rtl/control_unit_types_pkg.sv - shared types and constants for the request unit
//
// Purpose : Holds the request-unit FSM state enum and the width of the
//           link address (word address, bits [31:2] of a byte address).
// Ports   : none (package)
package control_unit_types_pkg;

  // Link-address compare width: byte address bits [31:2].
  localparam int LINK_ADDR_W = 30;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SCFAIL = 2'd2
  } ru_state_t;

endpackage

// File: rtl/link_register.sv
// rtl/link_register.sv - LL/SC reservation (link) register
//
// Purpose : Holds the reservation taken by a load-linked. A set always wins
//           over a clear or a matching invalidation arriving in the same cycle.
// Ports   : CLK, nRST           clock, asynchronous active-low reset
//           i_set, i_set_addr   take a reservation on a word address
//           i_clear             drop the reservation (SC done, store to link)
//           i_inv_valid/addr    coherence invalidation of a word address
//           o_valid, o_addr     current reservation
module link_register
  import control_unit_types_pkg::*;
#(
  parameter int ADDR_W = LINK_ADDR_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clear,
  input  logic              i_inv_valid,
  input  logic [ADDR_W-1:0] i_inv_addr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic              w_inv_hit;

  assign w_inv_hit = i_inv_valid && (i_inv_addr == r_addr);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (i_set) begin
      r_valid <= 1'b1;
      r_addr  <= i_set_addr;
    end else if (i_clear || w_inv_hit) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;

endmodule

// File: rtl/request_unit.sv
// rtl/request_unit.sv - data-request sequencer with optional LL/SC support
//
// Purpose : Turns decoded data-read/write requests into registered cache
//           requests held until dhit. Optional macro LLSC_EN adds the link
//           register, the SCFAIL state and store-conditional outcome.
// Ports   : CLK, nRST                   clock, asynchronous active-low reset
//           dRENi, dWENi, datomic, daddr decoded request from control unit
//           ihit, dhit                  fetch done / data access done
//           inv_valid, inv_addr         coherence invalidation
//           dREN, dWEN                  registered cache request
//           sc_result                   SC writeback value
//           busy                        request outstanding
module request_unit
  import control_unit_types_pkg::*;
#(
  parameter int WORD_ADDR_W = LINK_ADDR_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dRENi,
  input  logic        dWENi,
  input  logic        datomic,
  input  logic [31:0] daddr,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        inv_valid,
  input  logic [31:0] inv_addr,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] sc_result,
  output logic        busy
);

  ru_state_t              r_state;
  logic                   r_dren;
  logic                   r_dwen;
  logic                   r_is_write;
  logic                   r_is_atomic;
  logic [WORD_ADDR_W-1:0] r_addr;

  logic                   w_issue;
  logic                   w_is_write;
  logic                   w_atomic_in;
  logic                   w_sc_fail;
  logic [WORD_ADDR_W-1:0] w_daddr_word;

  assign w_issue      = (r_state == IDLE) && ihit && (dRENi || dWENi);
  // A read takes priority if both strobes arrive, so dREN/dWEN stay exclusive.
  assign w_is_write   = !dRENi;
  assign w_daddr_word = daddr[31 -: WORD_ADDR_W];

`ifdef LLSC_EN
  logic                   w_link_valid;
  logic [WORD_ADDR_W-1:0] w_link_addr;
  logic                   w_done;
  logic                   w_ll_done;
  logic                   w_sc_done;
  logic                   w_sw_hit;
  logic                   w_inv_issue_hit;
  logic                   w_unused;

  assign w_atomic_in     = datomic;
  assign w_done          = (r_state == REQ) && dhit;
  assign w_ll_done       = w_done && !r_is_write && r_is_atomic;
  assign w_sc_done       = w_done &&  r_is_write && r_is_atomic;
  assign w_sw_hit        = w_done &&  r_is_write && !r_is_atomic &&
                           w_link_valid && (r_addr == w_link_addr);
  // An invalidation landing on the SC's own word in its issue cycle kills it.
  assign w_inv_issue_hit = inv_valid && (inv_addr[31 -: WORD_ADDR_W] == w_daddr_word);
  assign w_sc_fail       = w_issue && w_is_write && datomic &&
                           (!w_link_valid || (w_link_addr != w_daddr_word) || w_inv_issue_hit);
  assign sc_result       = {31'd0, w_sc_done};
  assign w_unused        = &{1'b0, daddr, inv_addr};

  link_register #(
    .ADDR_W(WORD_ADDR_W)
  ) u_link (
    .CLK        (CLK),
    .nRST       (nRST),
    .i_set      (w_ll_done),
    .i_set_addr (r_addr),
    .i_clear    (w_sc_done || w_sw_hit),
    .i_inv_valid(inv_valid),
    .i_inv_addr (inv_addr[31 -: WORD_ADDR_W]),
    .o_valid    (w_link_valid),
    .o_addr     (w_link_addr)
  );
`else
  logic w_unused;

  // Without LL/SC an SC is an ordinary store that always "succeeds".
  assign w_atomic_in = 1'b0;
  assign w_sc_fail   = 1'b0;
  assign sc_result   = 32'd1;
  assign w_unused    = &{1'b0, datomic, daddr, inv_valid, inv_addr, r_addr, r_is_atomic};
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_dren      <= 1'b0;
      r_dwen      <= 1'b0;
      r_is_write  <= 1'b0;
      r_is_atomic <= 1'b0;
      r_addr      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_is_write  <= w_is_write;
            r_is_atomic <= w_atomic_in;
            r_addr      <= w_daddr_word;
            if (w_sc_fail) begin
              r_state <= SCFAIL;
            end else begin
              r_state <= REQ;
              r_dren  <= !w_is_write;
              r_dwen  <= w_is_write;
            end
          end
        end
        REQ: begin
          if (dhit) begin
            r_state <= IDLE;
            r_dren  <= 1'b0;
            r_dwen  <= 1'b0;
          end
        end
        SCFAIL: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_dren  <= 1'b0;
          r_dwen  <= 1'b0;
        end
      endcase
    end
  end

  assign dREN = r_dren;
  assign dWEN = r_dwen;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_request_unit.sv
// tb/tb_request_unit.sv - directed self-checking bench for request_unit
module tb_request_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dRENi, dWENi, datomic, ihit, dhit, inv_valid;
  logic [31:0] daddr, inv_addr;
  logic        dREN, dWEN, busy;
  logic [31:0] sc_result;

  int checks   = 0;
  int failures = 0;

`ifdef LLSC_EN
  localparam logic [31:0] SC_IDLE = 32'd0;
`else
  localparam logic [31:0] SC_IDLE = 32'd1;
`endif

  always #5 CLK = ~CLK;

  request_unit dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .dRENi    (dRENi),
    .dWENi    (dWENi),
    .datomic  (datomic),
    .daddr    (daddr),
    .ihit     (ihit),
    .dhit     (dhit),
    .inv_valid(inv_valid),
    .inv_addr (inv_addr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .sc_result(sc_result),
    .busy     (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    check_eq({tag, ".dREN"}, {31'd0, dREN}, 32'd0);
    check_eq({tag, ".dWEN"}, {31'd0, dWEN}, 32'd0);
    check_eq({tag, ".busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, ".sc"}, sc_result, SC_IDLE);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic at, input logic [31:0] a);
    daddr   = a;
    dRENi   = rd;
    dWENi   = wr;
    datomic = at;
    ihit    = 1'b1;
    tick();
    ihit    = 1'b0;
    dRENi   = 1'b0;
    dWENi   = 1'b0;
    datomic = 1'b0;
  endtask

  // Request already issued; hold for 'waits' cycles, then dhit.
  task automatic finish_req(input string tag, input int waits, input logic exp_ren,
                            input logic exp_wen, input logic [31:0] exp_sc);
    for (int i = 0; i < waits; i++) begin
      check_eq({tag, ".hold.dREN"}, {31'd0, dREN}, {31'd0, exp_ren});
      check_eq({tag, ".hold.dWEN"}, {31'd0, dWEN}, {31'd0, exp_wen});
      check_eq({tag, ".hold.busy"}, {31'd0, busy}, 32'd1);
      check_eq({tag, ".hold.sc"}, sc_result, SC_IDLE);
      tick();
    end
    dhit = 1'b1;
    #1;
    check_eq({tag, ".hit.dREN"}, {31'd0, dREN}, {31'd0, exp_ren});
    check_eq({tag, ".hit.dWEN"}, {31'd0, dWEN}, {31'd0, exp_wen});
    check_eq({tag, ".hit.sc"}, sc_result, exp_sc);
    @(posedge CLK);
    #1;
    dhit = 1'b0;
    chk_idle({tag, ".after"});
  endtask

  task automatic expect_scfail(input string tag);
    check_eq({tag, ".fail.dWEN"}, {31'd0, dWEN}, 32'd0);
    check_eq({tag, ".fail.dREN"}, {31'd0, dREN}, 32'd0);
    check_eq({tag, ".fail.busy"}, {31'd0, busy}, 32'd1);
    check_eq({tag, ".fail.sc"}, sc_result, 32'd0);
    tick();
    chk_idle({tag, ".fail.after"});
  endtask

  initial begin
    nRST = 1'b0; dRENi = 1'b0; dWENi = 1'b0; datomic = 1'b0; ihit = 1'b0;
    dhit = 1'b0; inv_valid = 1'b0; daddr = 32'd0; inv_addr = 32'd0;
    #12;
`ifdef LLSC_EN
    check_eq("reset.sc", sc_result, 32'd0);
`endif
    chk_idle("reset");
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    tick();

    // Plain load, held three cycles until dhit.
    issue(1'b1, 1'b0, 1'b0, 32'h100);
    finish_req("lw", 2, 1'b1, 1'b0, SC_IDLE);

    // ihit alone, or strobes without ihit, must not start a request.
    ihit = 1'b1; tick(); ihit = 1'b0;
    chk_idle("ihit_only");
    dRENi = 1'b1; daddr = 32'h180; tick(); dRENi = 1'b0;
    chk_idle("dreni_no_ihit");
    dWENi = 1'b1; tick(); dWENi = 1'b0;
    chk_idle("dweni_no_ihit");

    // Plain store completing in its first cycle.
    issue(1'b0, 1'b1, 1'b0, 32'h140);
    finish_req("sw", 0, 1'b0, 1'b1, SC_IDLE);

`ifdef LLSC_EN
    // LL then SC to the same word succeeds; a second SC fails (link consumed).
    issue(1'b1, 1'b0, 1'b1, 32'h200);
    finish_req("ll1", 1, 1'b1, 1'b0, 32'd0);
    issue(1'b0, 1'b1, 1'b1, 32'h200);
    finish_req("sc1", 1, 1'b0, 1'b1, 32'd1);
    issue(1'b0, 1'b1, 1'b1, 32'h200);
    expect_scfail("sc_again");

    // Matching invalidation between LL and SC.
    issue(1'b1, 1'b0, 1'b1, 32'h200);
    finish_req("ll2", 0, 1'b1, 1'b0, 32'd0);
    inv_valid = 1'b1; inv_addr = 32'h200; tick(); inv_valid = 1'b0;
    chk_idle("inv_idle");
    issue(1'b0, 1'b1, 1'b1, 32'h200);
    expect_scfail("sc_inv");

    // Non-matching invalidation leaves the link intact.
    issue(1'b1, 1'b0, 1'b1, 32'h200);
    finish_req("ll3", 0, 1'b1, 1'b0, 32'd0);
    inv_valid = 1'b1; inv_addr = 32'h280; tick(); inv_valid = 1'b0;
    issue(1'b0, 1'b1, 1'b1, 32'h200);
    finish_req("sc_inv_other", 0, 1'b0, 1'b1, 32'd1);

    // Store to a different word keeps the link; store to the linked word kills it.
    issue(1'b1, 1'b0, 1'b1, 32'h200);
    finish_req("ll4", 0, 1'b1, 1'b0, 32'd0);
    issue(1'b0, 1'b1, 1'b0, 32'h204);
    finish_req("sw204", 0, 1'b0, 1'b1, 32'd0);
    issue(1'b0, 1'b1, 1'b1, 32'h200);
    finish_req("sc_after_sw204", 0, 1'b0, 1'b1, 32'd1);
    issue(1'b1, 1'b0, 1'b1, 32'h200);
    finish_req("ll5", 0, 1'b1, 1'b0, 32'd0);
    issue(1'b0, 1'b1, 1'b0, 32'h200);
    finish_req("sw200", 0, 1'b0, 1'b1, 32'd0);
    issue(1'b0, 1'b1, 1'b1, 32'h200);
    expect_scfail("sc_after_sw200");

    // LL completion and invalidation in the same cycle: LL wins.
    issue(1'b1, 1'b0, 1'b1, 32'h200);
    inv_valid = 1'b1; inv_addr = 32'h200;
    finish_req("ll_vs_inv", 0, 1'b1, 1'b0, 32'd0);
    inv_valid = 1'b0;
    issue(1'b0, 1'b1, 1'b1, 32'h200);
    finish_req("sc_ll_won", 0, 1'b0, 1'b1, 32'd1);

    // Invalidation in the SC's issue cycle forces SCFAIL.
    issue(1'b1, 1'b0, 1'b1, 32'h200);
    finish_req("ll6", 0, 1'b1, 1'b0, 32'd0);
    inv_valid = 1'b1; inv_addr = 32'h200;
    issue(1'b0, 1'b1, 1'b1, 32'h200);
    inv_valid = 1'b0;
    expect_scfail("sc_inv_issue");

    // SC to a different word than the link fails.
    issue(1'b1, 1'b0, 1'b1, 32'h200);
    finish_req("ll7", 0, 1'b1, 1'b0, 32'd0);
    issue(1'b0, 1'b1, 1'b1, 32'h208);
    expect_scfail("sc_other_word");

    // Reset in the middle of an SC: dWEN drops at once and the link is gone.
    issue(1'b1, 1'b0, 1'b1, 32'h300);
    finish_req("ll8", 0, 1'b1, 1'b0, 32'd0);
    issue(1'b0, 1'b1, 1'b1, 32'h300);
    check_eq("rst.pre.dWEN", {31'd0, dWEN}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk_idle("rst.async");
    tick();
    nRST = 1'b1;
    tick();
    chk_idle("rst.release");
    issue(1'b0, 1'b1, 1'b1, 32'h300);
    expect_scfail("sc_after_rst");
`else
    // SC with no link behaves as a plain store, result always 1.
    issue(1'b0, 1'b1, 1'b1, 32'h200);
    finish_req("sc_nolink", 1, 1'b0, 1'b1, 32'd1);
    inv_valid = 1'b1; inv_addr = 32'h200;
    issue(1'b0, 1'b1, 1'b1, 32'h200);
    inv_valid = 1'b0;
    finish_req("sc_inv_ignored", 0, 1'b0, 1'b1, 32'd1);

    // Reset in the middle of a store: dWEN drops at once.
    issue(1'b0, 1'b1, 1'b1, 32'h300);
    check_eq("rst.pre.dWEN", {31'd0, dWEN}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk_idle("rst.async");
    tick();
    nRST = 1'b1;
    tick();
    chk_idle("rst.release");
    issue(1'b0, 1'b1, 1'b1, 32'h300);
    finish_req("sc_after_rst", 0, 1'b0, 1'b1, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Exclusivity of the two cache strobes, sampled away from the clock edge.
  always @(negedge CLK) begin
    if (dREN && dWEN) begin
      check_eq("excl", {30'd0, dREN, dWEN}, 32'd2);
    end
  end

endmodule
